// File: rtl/uart_pkg.sv
// Shared UART definitions so the FIFO, transmitter and receiver agree on
// data width and frame-option encodings.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   // Parity / check bit selection
   typedef enum logic [2:0] {
      CHK_NONE   = 3'd0,
      CHK_EVEN   = 3'd1,
      CHK_ODD    = 3'd2,
      CHK_FIXED0 = 3'd3,
      CHK_FIXED1 = 3'd4
   } check_mode_e;

   // Stop bit length selection
   typedef enum logic [1:0] {
      STOP_ONE      = 2'd0,
      STOP_ONE_HALF = 2'd1,
      STOP_TWO      = 2'd2
   } stop_mode_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port so the FIFO head is visible without a read cycle.
module uart_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are not reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// Wrap-bit pointers give empty/full directly; level is a separate counter
// kept in step with the pointers so status outputs need no subtraction.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] ONE = PW'(1);
   localparam logic [PW-1:0] AF  = PW'(AF_LEVEL);

   if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) ||
       (AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_param
      $error("uart_tx_fifo: DEPTH must be a power of two in 2..256 and AF_LEVEL in 1..DEPTH");
   end

   logic [PW-1:0] wr_ptr, rd_ptr, level_q;
   logic          overflow_q;
   logic          push, pop;

   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                        (wr_ptr[AW] != rd_ptr[AW]);
   assign s_ready     = !full;
   assign m_valid     = !empty;
   assign push        = s_valid && !full;
   assign pop         = m_valid && m_ready;
   assign level       = level_q;
   assign almost_full = (level_q >= AF);
   assign overflow    = overflow_q;

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk    (clk),
      .we     (push && !flush),
      .waddr  (wr_ptr[AW-1:0]),
      .wdata  (s_data),
      .raddr  (rd_ptr[AW-1:0]),
      .rdata  (m_data)
   );

   // Pointers and occupancy; flush overrides any concurrent push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE;
         if (pop)  rd_ptr <= rd_ptr + ONE;
         case ({push, pop})
            2'b10:   level_q <= level_q + ONE;
            2'b01:   level_q <= level_q - ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // Sticky flag for a byte offered while full (that byte is dropped).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 overflow_q <= 1'b0;
      else if (flush)             overflow_q <= 1'b0;
      else if (s_valid && full)   overflow_q <= 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int AF_LV  = 12;
   localparam int PW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [PW-1:0]     level;
   logic              empty, full, almost_full, overflow;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned q[$];
   bit           m_ovf = 1'b0;
   byte unsigned tx_log[$];

   uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LV)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .empty(empty), .full(full),
      .almost_full(almost_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus a sticky overflow bit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         bit was_full;
         bit do_pop;
         was_full = (q.size() == DEPTH);
         do_pop   = (q.size() > 0) && m_ready;
         if (s_valid && was_full) m_ovf = 1'b1;
         if (do_pop) void'(q.pop_front());
         if (s_valid && !was_full) q.push_back(s_data);
      end
   end

   // Compare DUT against the model every cycle, mid-period.
   always @(negedge clk) begin
      chk("level", int'(level), q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("s_ready", s_ready, q.size() != DEPTH);
      chk("m_valid", m_valid, q.size() != 0);
      chk("almost_full", almost_full, q.size() >= AF_LV);
      chk("overflow", overflow, m_ovf);
      if (q.size() != 0) chk("m_data", m_data, q[0]);
      if (rst_n && !flush && m_valid && m_ready) tx_log.push_back(m_data);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      byte unsigned exp_drain[$];
      int wait_cnt;

      // Reset then idle
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("rst_empty", empty, 1);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overflow", overflow, 0);

      // Single byte, held while the sink stalls
      s_valid = 1'b1; s_data = 8'h55;
      tick();
      s_valid = 1'b0;
      chk("one_m_valid", m_valid, 1);
      chk("one_m_data", m_data, 8'h55);
      chk("one_level", int'(level), 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_m_data", m_data, 8'h55);
      end
      do_flush();

      // Fill 0x00..0x0F, then overflow with 0xAA
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1; s_data = 8'(i);
         tick();
         chk("fill_af", almost_full, (i >= 11) ? 1 : 0);
         chk("fill_full", full, (i == 15) ? 1 : 0);
      end
      s_data = 8'hAA;
      tick();
      chk("ovf_set", overflow, 1);
      chk("ovf_level", int'(level), 16);
      chk("ovf_head", m_data, 8'h00);

      // Pop one while offering 0x77; 0x77 lands the next cycle
      s_data = 8'h77; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("pop_full_drop", full, 0);
      chk("pop_level", int'(level), 15);
      tick();
      s_valid = 1'b0;
      chk("refill_level", int'(level), 16);
      chk("refill_full", full, 1);
      tx_log.delete();
      m_ready = 1'b1;
      repeat (16) tick();
      m_ready = 1'b0;
      for (int i = 1; i < 16; i++) exp_drain.push_back(8'(i));
      exp_drain.push_back(8'h77);
      chk("drain_count", tx_log.size(), 16);
      for (int i = 0; i < 16 && i < tx_log.size(); i++)
         chk("drain_order", tx_log[i], exp_drain[i]);
      chk("drain_empty", empty, 1);
      do_flush();

      // Emulated 8N1 transmitter: one pop, then busy for a frame time
      tx_log.delete();
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 8'h31 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_cnt = 0;
         while (!m_valid && wait_cnt < 100) begin
            tick();
            wait_cnt++;
         end
         chk("tx_wait_timeout", wait_cnt < 100, 1);
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
         chk("tx_pops", tx_log.size(), k + 1);
         repeat (40) tick();
      end
      chk("tx_count", tx_log.size(), 3);
      for (int i = 0; i < 3 && i < tx_log.size(); i++)
         chk("tx_order", tx_log[i], 8'h31 + i);
      chk("tx_empty", empty, 1);

      // Overflow then flush with a concurrent byte
      for (int i = 0; i < 17; i++) begin
         s_valid = 1'b1; s_data = 8'hC0 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (11) tick();
      m_ready = 1'b0;
      chk("pre_flush_level", int'(level), 5);
      chk("pre_flush_ovf", overflow, 1);
      flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      chk("flush_level", int'(level), 0);
      chk("flush_empty", empty, 1);
      chk("flush_ovf", overflow, 0);
      tick();
      chk("flush_no_store", m_valid, 0);

      // Random traffic in phases of different push/pop pressure
      for (int c = 0; c < 3000; c++) begin
         int pv, pr;
         pv = (c / 500) % 3 == 0 ? 80 : ((c / 500) % 3 == 1 ? 30 : 55);
         pr = (c / 500) % 3 == 0 ? 30 : ((c / 500) % 3 == 1 ? 80 : 50);
         s_valid = ($urandom_range(0, 99) < pv);
         m_ready = ($urandom_range(0, 99) < pr);
         s_data  = 8'($urandom);
         flush   = ($urandom_range(0, 199) == 0);
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;
      do_flush();

      // Asynchronous reset in the middle of a drain
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_data = 8'h90 + 8'(i);
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (2) tick();
      #1 rst_n = 1'b0;
      #1;
      chk("arst_level", int'(level), 0);
      chk("arst_empty", empty, 1);
      chk("arst_full", full, 0);
      chk("arst_m_valid", m_valid, 0);
      chk("arst_s_ready", s_ready, 1);
      chk("arst_ovf", overflow, 0);
      chk("arst_af", almost_full, 0);
      repeat (2) tick();
      tx_log.delete();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("post_rst_level", int'(level), 0);
         chk("post_rst_m_valid", m_valid, 0);
      end
      chk("post_rst_pops", tx_log.size(), 0);
      m_ready = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
